// File: rtl/axis_multiport_lane_adder_pkg.sv
// rtl/axis_multiport_lane_adder_pkg.sv - shared types and lane arithmetic helpers for the multiport lane adder
package axis_mpadd_pkg;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] wide_t;

    typedef struct packed {
        wide_t value;
        logic  clipped;
    } sat_t;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_TWO
    } skid_state_t;

    function automatic int guard_w(input int num_ports);
        return $clog2(num_ports + 1);
    endfunction

    // Widen the low w bits of v to MAX_W, replicating bit w-1 when sgn is set.
    function automatic wide_t lane_ext(input wide_t v, input int w, input logic sgn);
        wide_t r;
        for (int i = 0; i < MAX_W; i++)
            r[i] = (i < w) ? v[i] : (sgn & v[w-1]);
        return r;
    endfunction

    // v must already be extended to MAX_W; clips into the acc_w-bit range.
    function automatic sat_t lane_sat(input wide_t v, input int acc_w, input logic sgn);
        sat_t r;
        logic signed [MAX_W-1:0] sv;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        sv = signed'(v);
        if (sgn) begin
            hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
            lo = -hi - 64'sd1;
        end else begin
            hi = (64'sd1 <<< acc_w) - 64'sd1;
            lo = '0;
        end
        r.clipped = (sv > hi) || (sv < lo);
        r.value   = (sv > hi) ? hi : ((sv < lo) ? lo : sv);
        return r;
    endfunction

endpackage

// File: rtl/axis_multiport_lane_adder_if.sv
// rtl/axis_multiport_lane_adder_if.sv - stream bundle with NUM parallel valid/last/ready bits
interface axis_mpadd_if #(
    parameter int DATA_W = 32,
    parameter int NUM    = 1
);
    logic [DATA_W-1:0] tdata;
    logic [NUM-1:0]    tvalid;
    logic [NUM-1:0]    tlast;
    logic [NUM-1:0]    tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_multiport_lane_adder_skid.sv
// rtl/axis_multiport_lane_adder_skid.sv - 2-entry skid buffer: output register plus one overflow entry
module axis_mpadd_skid
    import axis_mpadd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              full,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    skid_state_t       state_q, state_d;
    logic [DATA_W-1:0] out_q, skid_q;
    logic              load_in, load_skid, pop_skid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= SKID_EMPTY;
        else
            state_q <= state_d;
    end

    // in_valid is only raised by the caller while full is low.
    always_comb begin
        state_d   = state_q;
        load_in   = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (in_valid) begin
                    load_in = 1'b1;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (out_ready) begin
                    if (in_valid)
                        load_in = 1'b1;
                    else
                        state_d = SKID_EMPTY;
                end else if (in_valid) begin
                    load_skid = 1'b1;
                    state_d   = SKID_TWO;
                end
            end
            SKID_TWO: begin
                if (out_ready) begin
                    pop_skid = 1'b1;
                    state_d  = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_in)
                out_q <= in_data;
            else if (pop_skid)
                out_q <= skid_q;
            if (load_skid)
                skid_q <= in_data;
        end
    end

    assign out_valid = (state_q != SKID_EMPTY);
    assign full      = (state_q == SKID_TWO);
    assign out_data  = out_q;

endmodule

// File: rtl/axis_multiport_lane_adder.sv
// rtl/axis_multiport_lane_adder.sv - joins NUM_PORTS streams plus accin, lane-wise sum into a skid buffer
// Optional AXIS_MPADD_SAT_EN: saturating lane sums and a sat_flag output.
module axis_multiport_lane_adder
    import axis_mpadd_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int LANES     = 2,
    parameter int IN_W      = 16,
    parameter int ACC_W     = 32,
    parameter int SIGNED    = 1,
    parameter int CNT_W     = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    axis_mpadd_if.slave      s_axis,
    axis_mpadd_if.slave      s_axis_accin,
    axis_mpadd_if.master     m_axis,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             tlast_err
`ifdef AXIS_MPADD_SAT_EN
    ,
    output logic             sat_flag
`endif
);

    localparam int GUARD_W = guard_w(NUM_PORTS);
    localparam int SUM_W   = ACC_W + GUARD_W;
    localparam int PORT_W  = LANES * IN_W;
    localparam int OUT_W   = LANES * ACC_W;
    localparam logic SGN   = (SIGNED != 0);
`ifdef AXIS_MPADD_SAT_EN
    localparam int SKID_W  = OUT_W + 2;
`else
    localparam int SKID_W  = OUT_W + 1;
`endif

    logic              join_valid, skid_full, accept;
    logic [NUM_PORTS:0] tlast_all;
    logic              beat_last, tlast_bad;
    logic [SUM_W-1:0]  sum;
    logic [OUT_W-1:0]  lane_sum;
    logic [SKID_W-1:0] skid_in, skid_out;
    logic              out_valid;
`ifdef AXIS_MPADD_SAT_EN
    sat_t              sat_r;
    logic              lane_clip;
`endif

    // Ready is gated by reset and the registered skid_full only, never by m_axis.tready.
    assign join_valid          = (&s_axis.tvalid) & s_axis_accin.tvalid[0];
    assign accept              = join_valid & ~skid_full & aresetn;
    assign s_axis.tready       = {NUM_PORTS{accept}};
    assign s_axis_accin.tready = accept;

    assign tlast_all = {s_axis_accin.tlast[0], s_axis.tlast};
    assign beat_last = &tlast_all;
    assign tlast_bad = (|tlast_all) & ~beat_last;

    always_comb begin
        lane_sum = '0;
        sum      = '0;
`ifdef AXIS_MPADD_SAT_EN
        sat_r     = '0;
        lane_clip = 1'b0;
`endif
        for (int k = 0; k < LANES; k++) begin
            sum = SUM_W'(lane_ext(wide_t'(s_axis_accin.tdata[k*ACC_W +: ACC_W]), ACC_W, SGN));
            for (int p = 0; p < NUM_PORTS; p++)
                sum = sum + SUM_W'(lane_ext(wide_t'(s_axis.tdata[p*PORT_W + k*IN_W +: IN_W]), IN_W, SGN));
`ifdef AXIS_MPADD_SAT_EN
            sat_r     = lane_sat(lane_ext(wide_t'(sum), SUM_W, SGN), ACC_W, SGN);
            lane_sum[k*ACC_W +: ACC_W] = ACC_W'(sat_r.value);
            lane_clip = lane_clip | sat_r.clipped;
`else
            lane_sum[k*ACC_W +: ACC_W] = ACC_W'(sum);
`endif
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
            tlast_err <= 1'b0;
        end else if (accept) begin
            if (tlast_bad)
                tlast_err <= 1'b1;
            if (beat_last) begin
                beat_cnt  <= '0;
                frame_cnt <= frame_cnt + 1'b1;
            end else if (beat_cnt != '1) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

`ifdef AXIS_MPADD_SAT_EN
    assign skid_in = {lane_sum, beat_last, lane_clip};
`else
    assign skid_in = {lane_sum, beat_last};
`endif

    axis_mpadd_skid #(.DATA_W(SKID_W)) u_skid (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_valid  (accept),
        .in_data   (skid_in),
        .full      (skid_full),
        .out_valid (out_valid),
        .out_data  (skid_out),
        .out_ready (m_axis.tready[0])
    );

    assign m_axis.tvalid = out_valid;
`ifdef AXIS_MPADD_SAT_EN
    assign m_axis.tdata  = skid_out[SKID_W-1:2];
    assign m_axis.tlast  = skid_out[1];
    assign sat_flag      = skid_out[0];
`else
    assign m_axis.tdata  = skid_out[SKID_W-1:1];
    assign m_axis.tlast  = skid_out[0];
`endif

endmodule
